// File: rtl/ofm_write_scheduler_if.sv
// OFM memory write port: valid/ready handshake carrying address and data.
// master = write scheduler, slave = OFM memory.
interface ofm_write_scheduler_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic              mem_wr_valid;
   logic              mem_wr_ready;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;

   modport master (
      output mem_wr_valid,
      output mem_wr_addr,
      output mem_wr_data,
      input  mem_wr_ready
   );

   modport slave (
      input  mem_wr_valid,
      input  mem_wr_addr,
      input  mem_wr_data,
      output mem_wr_ready
   );
endinterface

// File: rtl/ofm_write_scheduler.sv
// OFM write scheduler: buffers the non-stallable systolic-array row stream in a
// small FIFO and writes it to OFM memory in channel-major order
// (addr = (group*SYSTOLIC_SIZE + row)*NO_TILE + tile).
// Optional build macro OFM_RELU_EN: clamp negative output words to zero.
module ofm_write_scheduler #(
   parameter int SYSTOLIC_SIZE  = 16,
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 16,
   parameter int NO_TILE        = 64,
   parameter int NO_LOAD_FILTER = 1,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    in_data,
   ofm_write_scheduler_if.master m_if,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int ROW_W  = (SYSTOLIC_SIZE  > 1) ? $clog2(SYSTOLIC_SIZE)  : 1;
   localparam int TILE_W = (NO_TILE        > 1) ? $clog2(NO_TILE)        : 1;
   localparam int GRP_W  = (NO_LOAD_FILTER > 1) ? $clog2(NO_LOAD_FILTER) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [ADDR_W-1:0] C_ROW_STEP = ADDR_W'(NO_TILE);
   localparam logic [ADDR_W-1:0] C_ROW_BACK = ADDR_W'((SYSTOLIC_SIZE - 1) * NO_TILE - 1);
   localparam logic [ADDR_W-1:0] C_GRP_STEP = ADDR_W'(SYSTOLIC_SIZE * NO_TILE);

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W:0]    r_wptr, r_rptr;
   logic [ROW_W-1:0]  r_row;
   logic [TILE_W-1:0] r_tile;
   logic [GRP_W-1:0]  r_grp;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_grp_base;
   logic              r_overflow;

   logic              w_run, w_empty, w_full, w_valid, w_hs;
   logic              w_row_end, w_tile_end, w_grp_end, w_last;
   logic              w_push, w_drop, w_leftover;
   logic [PTR_W:0]    w_count;
   logic [DATA_W-1:0] w_head, w_out_data;

   assign w_run      = (r_state == S_RUN);
   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
   assign w_count    = r_wptr - r_rptr;
   assign w_valid    = w_run && !w_empty;
   assign w_hs       = w_valid && m_if.mem_wr_ready;
   assign w_row_end  = (r_row  == ROW_W'(SYSTOLIC_SIZE - 1));
   assign w_tile_end = (r_tile == TILE_W'(NO_TILE - 1));
   assign w_grp_end  = (r_grp  == GRP_W'(NO_LOAD_FILTER - 1));
   assign w_last     = w_hs && w_row_end && w_tile_end && w_grp_end;
   // Words arriving in the final-beat cycle belong to no beat and are ignored.
   assign w_push     = w_run && in_valid && !w_last && (!w_full || w_hs);
   assign w_drop     = w_run && in_valid && !w_last && w_full && !w_hs;
   assign w_leftover = w_last && (w_count != (PTR_W+1)'(1));
   assign w_head     = r_mem[r_rptr[PTR_W-1:0]];

`ifdef OFM_RELU_EN
   assign w_out_data = w_head[DATA_W-1] ? '0 : w_head;
`else
   assign w_out_data = w_head;
`endif

   assign m_if.mem_wr_valid = w_valid;
   assign m_if.mem_wr_addr  = r_addr;
   assign m_if.mem_wr_data  = w_valid ? w_out_data : '0;
   assign busy              = w_run;
   assign done              = (r_state == S_DONE);
   assign overflow          = r_overflow;

   // FIFO storage write; a full FIFO may be written in the slot being popped.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[PTR_W-1:0]] <= in_data;
      end
   end

   // Layer FSM, FIFO pointers, beat counters and incremental address generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_row      <= '0;
         r_tile     <= '0;
         r_grp      <= '0;
         r_addr     <= '0;
         r_grp_base <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_RUN;
                  r_wptr     <= '0;
                  r_rptr     <= '0;
                  r_row      <= '0;
                  r_tile     <= '0;
                  r_grp      <= '0;
                  r_addr     <= '0;
                  r_grp_base <= C_GRP_STEP;
                  r_overflow <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_push) begin
                  r_wptr <= r_wptr + 1'b1;
               end
               if (w_drop) begin
                  r_overflow <= 1'b1;
               end
               // Address walks by constant steps; r_grp_base holds the next
               // group's base so the group jump needs no multiply either.
               if (w_hs) begin
                  r_rptr <= r_rptr + 1'b1;
                  if (w_row_end) begin
                     r_row <= '0;
                     if (w_tile_end) begin
                        r_tile     <= '0;
                        r_grp      <= w_grp_end ? '0 : r_grp + 1'b1;
                        r_addr     <= r_grp_base;
                        r_grp_base <= r_grp_base + C_GRP_STEP;
                     end else begin
                        r_tile <= r_tile + 1'b1;
                        r_addr <= r_addr - C_ROW_BACK;
                     end
                  end else begin
                     r_row  <= r_row + 1'b1;
                     r_addr <= r_addr + C_ROW_STEP;
                  end
               end
               if (w_last) begin
                  r_state <= S_DONE;
                  r_rptr  <= r_wptr;
                  if (w_leftover) begin
                     r_overflow <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ofm_write_scheduler.sv
// Directed bench for ofm_write_scheduler with SYSTOLIC_SIZE=4, NO_TILE=2,
// NO_LOAD_FILTER=2, FIFO_DEPTH=4 (16 beats per layer).
module tb_ofm_write_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        busy, done, overflow;

   int checks = 0;
   int errors = 0;
   int nb = 0;
   logic [31:0] exp_q [$];

   // Hand-computed channel-major address sequence for S=4, T=2, G=2.
   int addr_exp [0:15] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};

   typedef struct {
      logic        st;
      logic        iv;
      logic [31:0] d;
      logic        rdy;
      logic        e_v;
      logic [15:0] e_a;
      logic [31:0] e_d;
      logic        e_busy;
      logic        e_done;
      logic        e_ovf;
      logic        chk_ad;
   } vec_t;

   vec_t tv [19];

   ofm_write_scheduler_if #(.DATA_W(32), .ADDR_W(16)) m_if ();

   ofm_write_scheduler #(
      .SYSTOLIC_SIZE (4),
      .DATA_W        (32),
      .ADDR_W        (16),
      .NO_TILE       (2),
      .NO_LOAD_FILTER(2),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in_valid(in_valid),
      .in_data (in_data),
      .m_if    (m_if.master),
      .busy    (busy),
      .done    (done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, clock, sample #1 after the edge; track handshakes.
   task automatic cyc(input logic iv, input logic [31:0] d, input logic rdy, input logic st);
      logic hs;
      hs = m_if.mem_wr_valid && rdy;
      start = st;
      in_valid = iv;
      in_data = d;
      m_if.mem_wr_ready = rdy;
      @(posedge clk);
      #1;
      if (hs) begin
         nb++;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   // Feed nwords (1/cycle) and scoreboard every presented beat until done.
   task automatic stream(input int nwords, input int dbase, input int stall_beat,
                         input int stall_len, input int start_at, input logic exp_ovf);
      int   sent = 0;
      int   stalled = 0;
      int   n = 0;
      logic rdy, iv;
      logic seen_done = 1'b0;
      exp_q.delete();
      while (!seen_done && n < 200) begin
         if (m_if.mem_wr_valid) begin
            if (nb < 16) chk("stream_addr", 32'(m_if.mem_wr_addr), addr_exp[nb]);
            else         chk("stream_extra_beat", 32'(nb), 32'd15);
            if (exp_q.size() == 0) chk("stream_spurious_valid", 32'd1, 32'd0);
            else                   chk("stream_data", m_if.mem_wr_data, exp_q[0]);
         end
         rdy = !(m_if.mem_wr_valid && nb == stall_beat && stalled < stall_len);
         if (!rdy) stalled++;
         iv = (sent < nwords);
         if (iv) exp_q.push_back(32'(dbase + sent));
         cyc(iv, 32'(dbase + sent), rdy, n == start_at);
         if (iv) sent++;
         n++;
         if (done) seen_done = 1'b1;
      end
      chk("stream_done_seen", 32'(seen_done), 32'd1);
      chk("stream_beats", 32'(nb), 32'd16);
      chk("stream_busy_in_done", 32'(busy), 32'd0);
      chk("stream_valid_in_done", 32'(m_if.mem_wr_valid), 32'd0);
      chk("stream_overflow", 32'(overflow), 32'(exp_ovf));
      chk("stream_leftover", 32'(exp_q.size()), 32'd0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("stream_done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      m_if.mem_wr_ready = 1'b0;

      // Table: address order at 1 word/cycle with ready held high.
      tv[0] = '{st:1'b1, iv:1'b0, d:'0, rdy:1'b1, e_v:1'b0, e_a:'0, e_d:'0,
                e_busy:1'b1, e_done:1'b0, e_ovf:1'b0, chk_ad:1'b0};
      for (int k = 1; k <= 16; k++) begin
         tv[k] = '{st:1'b0, iv:1'b1, d:32'(k-1), rdy:1'b1, e_v:1'b1,
                   e_a:16'(addr_exp[k-1]), e_d:32'(k-1),
                   e_busy:1'b1, e_done:1'b0, e_ovf:1'b0, chk_ad:1'b1};
      end
      tv[17] = '{st:1'b0, iv:1'b0, d:'0, rdy:1'b1, e_v:1'b0, e_a:'0, e_d:'0,
                 e_busy:1'b0, e_done:1'b1, e_ovf:1'b0, chk_ad:1'b0};
      tv[18] = '{st:1'b0, iv:1'b0, d:'0, rdy:1'b1, e_v:1'b0, e_a:'0, e_d:'0,
                 e_busy:1'b0, e_done:1'b0, e_ovf:1'b0, chk_ad:1'b0};

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(m_if.mem_wr_valid), 32'd0);
      chk("rst_addr", 32'(m_if.mem_wr_addr), 32'd0);
      chk("rst_data", m_if.mem_wr_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      cyc(1'b0, '0, 1'b0, 1'b0);

      // Address order via vector table.
      nb = 0;
      for (int i = 0; i < 19; i++) begin
         cyc(tv[i].iv, tv[i].d, tv[i].rdy, tv[i].st);
         chk("tbl_valid", 32'(m_if.mem_wr_valid), 32'(tv[i].e_v));
         chk("tbl_busy", 32'(busy), 32'(tv[i].e_busy));
         chk("tbl_done", 32'(done), 32'(tv[i].e_done));
         chk("tbl_overflow", 32'(overflow), 32'(tv[i].e_ovf));
         if (tv[i].chk_ad) begin
            chk("tbl_addr", 32'(m_if.mem_wr_addr), 32'(tv[i].e_a));
            chk("tbl_data", m_if.mem_wr_data, tv[i].e_d);
         end
      end

      // in_valid in IDLE is ignored.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'hAAAA_0000 + 32'(i), 1'b1, 1'b0);
         chk("idle_valid", 32'(m_if.mem_wr_valid), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_overflow", 32'(overflow), 32'd0);
      end

      // Backpressure: beat 5 stalled 3 cycles while words keep arriving.
      cyc(1'b0, '0, 1'b1, 1'b1);
      nb = 0;
      chk("bp_no_stale_word", 32'(m_if.mem_wr_valid), 32'd0);
      stream(16, 0, 5, 3, -1, 1'b0);

      // start pulse during RUN does not restart the sequence.
      cyc(1'b0, '0, 1'b1, 1'b1);
      nb = 0;
      stream(16, 32'h1000, 99, 0, 7, 1'b0);

      // Overflow: ready low, 5 words pushed, 5th dropped.
      cyc(1'b0, '0, 1'b0, 1'b1);
      nb = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 32'd100 + 32'(i), 1'b0, 1'b0);
         if (i == 3) chk("ovf_after4", 32'(overflow), 32'd0);
         if (i == 4) chk("ovf_after5", 32'(overflow), 32'd1);
      end
      chk("ovf_hold_valid", 32'(m_if.mem_wr_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain_addr", 32'(m_if.mem_wr_addr), addr_exp[i]);
         chk("ovf_drain_data", m_if.mem_wr_data, 32'd100 + 32'(i));
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      chk("ovf_fifth_dropped", 32'(m_if.mem_wr_valid), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      stream(12, 200, 99, 0, -1, 1'b1);
      chk("ovf_sticky_idle", 32'(overflow), 32'd1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      nb = 0;
      chk("ovf_cleared_by_start", 32'(overflow), 32'd0);

      // Full FIFO with simultaneous push and pop.
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'd300 + 32'(i), 1'b0, 1'b0);
      chk("full_ovf0", 32'(overflow), 32'd0);
      chk("full_head", m_if.mem_wr_data, 32'd300);
      cyc(1'b1, 32'd304, 1'b1, 1'b0);
      chk("full_simul_ovf", 32'(overflow), 32'd0);
      chk("full_simul_head", m_if.mem_wr_data, 32'd301);
      chk("full_simul_addr", 32'(m_if.mem_wr_addr), 32'd2);
      cyc(1'b1, 32'd305, 1'b0, 1'b0);
      chk("full_still_4", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("full_drain_addr", 32'(m_if.mem_wr_addr), addr_exp[1+i]);
         chk("full_drain_data", m_if.mem_wr_data, 32'd301 + 32'(i));
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      chk("full_drained", 32'(m_if.mem_wr_valid), 32'd0);
      stream(11, 400, 99, 0, -1, 1'b1);

      // Reset mid-run after 6 beats.
      cyc(1'b0, '0, 1'b1, 1'b1);
      nb = 0;
      for (int i = 0; i < 20 && nb < 6; i++) cyc(1'b1, 32'd500 + 32'(i), 1'b1, 1'b0);
      chk("mid_beats", 32'(nb), 32'd6);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(m_if.mem_wr_valid), 32'd0);
      chk("mid_rst_addr", 32'(m_if.mem_wr_addr), 32'd0);
      chk("mid_rst_data", m_if.mem_wr_data, 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, '0, 1'b1, 1'b1);
         chk("mid_rst_no_done", 32'(done), 32'd0);
         chk("mid_rst_no_busy", 32'(busy), 32'd0);
      end
      rst = 1'b0;
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("mid_after_rst_done", 32'(done), 32'd0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      nb = 0;
      stream(16, 600, 99, 0, -1, 1'b0);

      // Output data path: negative word, then positive word.
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
`ifdef OFM_RELU_EN
      chk("relu_negative", m_if.mem_wr_data, 32'h0000_0000);
`else
      chk("pass_negative", m_if.mem_wr_data, 32'hFFFF_FFF0);
`endif
      cyc(1'b1, 32'h0000_0010, 1'b1, 1'b0);
      chk("positive_pass", m_if.mem_wr_data, 32'h0000_0010);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      chk("final_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
